inst_loader: RTL

Boot-time program loader sitting directly upstream of the CPU core. It consumes a byte stream from the UART receive path and assembles big-endian 32-bit instruction words. It writes those words into instruction memory starting at address 0, verifies an XOR checksum, and then issues a one-cycle `start` that releases the core from INIT. Any protocol violation latches an error, and the core is never started.

---
 rtl/inst_loader.sv | 170 +++++++++++++++++
 1 files changed

// File: rtl/inst_loader.sv
// inst_loader: boot-time program loader. Assembles big-endian 32-bit words
// from a UART byte stream, writes them to instruction memory from address 0,
// checks an XOR checksum and pulses start to release the core.
module inst_loader #(
    parameter int unsigned ADDR_WIDTH = 8,
    parameter int unsigned MAX_WORDS  = 200
) (
    input  logic                  CLK,
    input  logic                  RST,
    input  logic [7:0]            rx_data,
    input  logic                  rx_valid,
    output logic                  rx_ready,
    output logic                  imem_we,
    output logic [ADDR_WIDTH-1:0] imem_addr,
    output logic [31:0]           imem_wdata,
    output logic                  busy,
    output logic                  load_done,
    output logic                  load_err,
    output logic                  start
);

    localparam int unsigned IDX_W = ADDR_WIDTH + 1;

    typedef enum logic [2:0] {
        ST_HDR  = 3'd0,
        ST_DATA = 3'd1,
        ST_CSUM = 3'd2,
        ST_DONE = 3'd3,
        ST_ERR  = 3'd4
    } state_t;

    state_t r_state;
    state_t w_state_next;

    logic [1:0]            r_byte_cnt;
    logic [31:0]           r_count;
    logic [23:0]           r_word;
    logic [IDX_W-1:0]      r_widx;
    logic [7:0]            r_xor;

    logic                  r_rx_ready;
    logic                  r_imem_we;
    logic [ADDR_WIDTH-1:0] r_imem_addr;
    logic [31:0]           r_imem_wdata;
    logic                  r_busy;
    logic                  r_load_done;
    logic                  r_load_err;
    logic                  r_start;

    logic                  w_loading;
    logic                  w_accept;
    logic                  w_write;
    logic                  w_loading_next;
    logic [31:0]           w_count_next;
    logic [31:0]           w_word_next;
    logic [IDX_W-1:0]      w_widx_inc;

    assign w_loading    = (r_state == ST_HDR) || (r_state == ST_DATA) || (r_state == ST_CSUM);
    assign w_accept     = rx_valid && w_loading;
    assign w_count_next = {r_count[23:0], rx_data};
    assign w_word_next  = {r_word, rx_data};
    assign w_widx_inc   = r_widx + IDX_W'(1);

    // State register
    always_ff @(posedge CLK) begin
        if (RST) begin
            r_state <= ST_HDR;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Next-state decode and write strobe
    always_comb begin
        w_state_next = r_state;
        w_write      = 1'b0;
        case (r_state)
            ST_HDR: begin
                if (w_accept && (r_byte_cnt == 2'd3)) begin
                    if (w_count_next > 32'(MAX_WORDS)) begin
                        w_state_next = ST_ERR;
                    end else if (w_count_next == 32'd0) begin
                        w_state_next = ST_CSUM;
                    end else begin
                        w_state_next = ST_DATA;
                    end
                end
            end
            ST_DATA: begin
                if (w_accept && (r_byte_cnt == 2'd3)) begin
                    w_write = 1'b1;
                    if (32'(w_widx_inc) == r_count) begin
                        w_state_next = ST_CSUM;
                    end
                end
            end
            ST_CSUM: begin
                if (w_accept) begin
                    w_state_next = (rx_data == r_xor) ? ST_DONE : ST_ERR;
                end
            end
            ST_DONE: w_state_next = ST_DONE;
            ST_ERR:  w_state_next = ST_ERR;
            default: w_state_next = ST_ERR;
        endcase
    end

    assign w_loading_next = (w_state_next == ST_HDR) || (w_state_next == ST_DATA) ||
                            (w_state_next == ST_CSUM);

    // Byte assembly, word index and running XOR
    always_ff @(posedge CLK) begin
        if (RST) begin
            r_byte_cnt <= 2'd0;
            r_count    <= 32'd0;
            r_word     <= 24'd0;
            r_widx     <= '0;
            r_xor      <= 8'd0;
        end else begin
            if (w_accept && ((r_state == ST_HDR) || (r_state == ST_DATA))) begin
                r_xor      <= r_xor ^ rx_data;
                r_byte_cnt <= r_byte_cnt + 2'd1;
            end
            if (w_accept && (r_state == ST_HDR)) begin
                r_count <= w_count_next;
            end
            if (w_accept && (r_state == ST_DATA)) begin
                r_word <= w_word_next[23:0];
            end
            if (w_write) begin
                r_widx <= w_widx_inc;
            end
        end
    end

    // Registered outputs: memory write port, handshake and status
    always_ff @(posedge CLK) begin
        if (RST) begin
            r_rx_ready   <= 1'b1;
            r_imem_we    <= 1'b0;
            r_imem_addr  <= '0;
            r_imem_wdata <= 32'd0;
            r_busy       <= 1'b1;
            r_load_done  <= 1'b0;
            r_load_err   <= 1'b0;
            r_start      <= 1'b0;
        end else begin
            r_imem_we <= w_write;
            if (w_write) begin
                r_imem_addr  <= r_widx[ADDR_WIDTH-1:0];
                r_imem_wdata <= w_word_next;
            end
            r_rx_ready  <= w_loading_next;
            r_busy      <= w_loading_next;
            r_load_done <= (w_state_next == ST_DONE);
            r_load_err  <= (w_state_next == ST_ERR);
            r_start     <= (r_state == ST_CSUM) && (w_state_next == ST_DONE);
        end
    end

    assign rx_ready   = r_rx_ready;
    assign imem_we    = r_imem_we;
    assign imem_addr  = r_imem_addr;
    assign imem_wdata = r_imem_wdata;
    assign busy       = r_busy;
    assign load_done  = r_load_done;
    assign load_err   = r_load_err;
    assign start      = r_start;

endmodule
